// File: rtl/gcbp_bram_reader_pkg.sv
// Shared geometry, FSM encoding and address helpers for the GCBP BRAM read path.
package gcbp_bram_reader_pkg;

  localparam int SUBIMAGE_H      = 64;
  localparam int C_NUM_SUBIMAGES = 16;
  localparam int C_REGION_DEPTH  = 128;
  localparam int C_DATA_W        = 128;

  localparam int LINE_W = $clog2(SUBIMAGE_H);
  localparam int SUB_W  = $clog2(C_NUM_SUBIMAGES);
  localparam int LOC_W  = 2;
  localparam int ADDR_W = LOC_W + $clog2(C_REGION_DEPTH);
  localparam int PAD_W  = ADDR_W - LOC_W - LINE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CURR,
    S_RD_PREV,
    S_CAPTURE,
    S_OUT
  } state_t;

  // BRAM k occupies bits [k*C_DATA_W +: C_DATA_W], same order as the write enables
  typedef logic [C_NUM_SUBIMAGES-1:0][C_DATA_W-1:0] bram_rd_t;

  // Only the lower half of each frame region holds lines, so the pad bits stay 0
  function automatic logic [ADDR_W-1:0] compose_addr(input logic [LOC_W-1:0] loc,
                                                     input logic [LINE_W-1:0] line);
    return {loc, {PAD_W{1'b0}}, line};
  endfunction

endpackage

// File: rtl/gcbp_read_addr_gen.sv
// Sub-image/line walk, latched frame regions and shared BRAM read address.
module gcbp_read_addr_gen
  import gcbp_bram_reader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_clr,
  input  logic              i_adv,
  input  logic              i_rd_curr,
  input  logic              i_rd_prev,
  input  logic [LOC_W-1:0]  i_curr_loc,
  input  logic [LOC_W-1:0]  i_prev_loc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [SUB_W-1:0]  o_sub,
  output logic [LINE_W-1:0] o_line,
  output logic              o_last
);

  logic [LOC_W-1:0]  r_curr_loc, r_prev_loc;
  logic [SUB_W-1:0]  r_sub;
  logic [LINE_W-1:0] r_line;
  logic [ADDR_W-1:0] r_addr_hold;
  logic [ADDR_W-1:0] curr_addr, prev_addr;

  assign curr_addr = compose_addr(r_curr_loc, r_line);
  assign prev_addr = compose_addr(r_prev_loc, r_line);
  assign o_last    = (r_sub == SUB_W'(C_NUM_SUBIMAGES-1)) && (r_line == LINE_W'(SUBIMAGE_H-1));

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_curr_loc  <= '0;
      r_prev_loc  <= '0;
      r_sub       <= '0;
      r_line      <= '0;
      r_addr_hold <= '0;
    end else begin
      if (i_clr) begin
        r_curr_loc <= i_curr_loc;
        r_prev_loc <= i_prev_loc;
        r_sub      <= '0;
        r_line     <= '0;
      end else if (i_adv) begin
        if (o_last) begin
          r_sub  <= '0;
          r_line <= '0;
        end else if (r_line == LINE_W'(SUBIMAGE_H-1)) begin
          r_line <= '0;
          r_sub  <= r_sub + 1'b1;
        end else begin
          r_line <= r_line + 1'b1;
        end
      end
      if (i_rd_curr)      r_addr_hold <= curr_addr;
      else if (i_rd_prev) r_addr_hold <= prev_addr;
    end
  end

  // Address is live during the two read states and frozen otherwise
  always_comb begin
    o_addr = r_addr_hold;
    if (i_rd_curr)      o_addr = curr_addr;
    else if (i_rd_prev) o_addr = prev_addr;
  end

  assign o_sub  = r_sub;
  assign o_line = r_line;

endmodule

// File: rtl/gcbp_bram_reader.sv
// Streams every sub-image line of the current/previous frame pair to the motion-match engine.
module gcbp_bram_reader
  import gcbp_bram_reader_pkg::*;
(
  input  logic                                  i_clk,
  input  logic                                  i_resetn,
  input  logic                                  i_start,
  input  logic [LOC_W-1:0]                      i_curr_frame_loc,
  input  logic [LOC_W-1:0]                      i_prev_frame_loc,
  output logic [ADDR_W-1:0]                     o_bram_array_read_addr,
  input  logic [C_NUM_SUBIMAGES*C_DATA_W-1:0]   i_bram_array_read_data,
  output logic [C_DATA_W-1:0]                   o_curr_line,
  output logic [C_DATA_W-1:0]                   o_prev_line,
  output logic [SUB_W-1:0]                      o_subimage_idx,
  output logic [LINE_W-1:0]                     o_line_idx,
  output logic                                  o_last,
  output logic                                  o_valid,
  input  logic                                  i_ready,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic                                  o_loc_err
);

  state_t   state, state_nxt;
  bram_rd_t rd;
  logic     locs_eq, accept, reject, rd_curr, rd_prev, cap_curr, cap_prev, hs, fin, last_raw;
  logic [SUB_W-1:0] sub;

  assign rd      = i_bram_array_read_data;
  assign locs_eq = (i_curr_frame_loc == i_prev_frame_loc);

  gcbp_read_addr_gen u_addr_gen (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_clr      (accept),
    .i_adv      (hs),
    .i_rd_curr  (rd_curr),
    .i_rd_prev  (rd_prev),
    .i_curr_loc (i_curr_frame_loc),
    .i_prev_loc (i_prev_frame_loc),
    .o_addr     (o_bram_array_read_addr),
    .o_sub      (sub),
    .o_line     (o_line_idx),
    .o_last     (last_raw)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (i_start && !locs_eq) state_nxt = S_RD_CURR;
      S_RD_CURR: state_nxt = S_RD_PREV;
      S_RD_PREV: state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_OUT;
      S_OUT:     if (i_ready) state_nxt = last_raw ? S_IDLE : S_RD_CURR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state == S_IDLE) && i_start && !locs_eq;
    reject   = (state == S_IDLE) && i_start && locs_eq;
    rd_curr  = (state == S_RD_CURR);
    rd_prev  = (state == S_RD_PREV);
    cap_curr = (state == S_RD_PREV);
    cap_prev = (state == S_CAPTURE);
    hs       = (state == S_OUT) && i_ready;
    fin      = hs && last_raw;
  end

  // Data returns one cycle after its address, so each read state captures the previous one's word
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_curr_line <= '0;
      o_prev_line <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_loc_err   <= 1'b0;
    end else begin
      if (cap_curr) o_curr_line <= rd[sub];
      if (cap_prev) o_prev_line <= rd[sub];
      o_valid   <= (state_nxt == S_OUT);
      o_busy    <= (state_nxt != S_IDLE);
      o_done    <= fin;
      o_loc_err <= reject;
    end
  end

  assign o_subimage_idx = sub;
  assign o_last         = o_valid && last_raw;

endmodule

// File: tb/tb_gcbp_bram_reader.sv
// Directed bench for gcbp_bram_reader with a behavioural 16-BRAM array model.
module tb_gcbp_bram_reader;

  logic           i_clk = 1'b0;
  logic           i_resetn = 1'b0;
  logic           i_start = 1'b0;
  logic [1:0]     i_curr_frame_loc = 2'd0;
  logic [1:0]     i_prev_frame_loc = 2'd0;
  logic [8:0]     o_bram_array_read_addr;
  logic [15:0][127:0] mem_q;
  logic [127:0]   o_curr_line, o_prev_line;
  logic [3:0]     o_subimage_idx;
  logic [5:0]     o_line_idx;
  logic           o_last, o_valid, o_busy, o_done, o_loc_err;
  logic           i_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  gcbp_bram_reader dut (
    .i_clk                  (i_clk),
    .i_resetn               (i_resetn),
    .i_start                (i_start),
    .i_curr_frame_loc       (i_curr_frame_loc),
    .i_prev_frame_loc       (i_prev_frame_loc),
    .o_bram_array_read_addr (o_bram_array_read_addr),
    .i_bram_array_read_data (mem_q),
    .o_curr_line            (o_curr_line),
    .o_prev_line            (o_prev_line),
    .o_subimage_idx         (o_subimage_idx),
    .o_line_idx             (o_line_idx),
    .o_last                 (o_last),
    .o_valid                (o_valid),
    .i_ready                (i_ready),
    .o_busy                 (o_busy),
    .o_done                 (o_done),
    .o_loc_err              (o_loc_err)
  );

  // Word contents encode BRAM index and full address, so any wrong loc/line/slot shows up
  function automatic logic [127:0] pat(input int k, input logic [8:0] a);
    return {24'hC0FFEE, 4'(k), 4'h0, {23'h0, a}, 32'(k * 1000 + int'(a)), ~{23'h0, a}};
  endfunction

  always @(posedge i_clk)
    for (int k = 0; k < 16; k++) mem_q[k] <= pat(k, o_bram_array_read_addr);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    i_resetn = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_resetn = 1'b1;
  endtask

  task automatic run_pass(input logic [1:0] c, input logic [1:0] p, input int stall_at,
                          input int chg_at, input int restart_at, input int rst_at);
    int cyc, pairs, last_acc, stall_cnt, seen;
    logic fin, restarted;
    logic [127:0] snap;
    cyc = 0; pairs = 0; last_acc = 0; stall_cnt = 0; seen = -1;
    fin = 1'b0; restarted = 1'b0; snap = '0;
    i_curr_frame_loc = c;
    i_prev_frame_loc = p;
    i_ready = 1'b1;
    i_start = 1'b1;
    while (cyc < 6000 && !fin) begin
      @(negedge i_clk);
      cyc++;
      i_start = 1'b0;
      i_ready = 1'b1;
      if (o_busy) chk("addr_pad", 128'(o_bram_array_read_addr[6]), 128'(0));
      if (o_valid) begin
        if (seen != pairs) begin
          chk("pair_latency", 128'(cyc), 128'(pairs == 0 ? 4 : last_acc + 4));
          seen = pairs;
        end
        chk("sub", 128'(o_subimage_idx), 128'(pairs / 64));
        chk("line", 128'(o_line_idx), 128'(pairs % 64));
        chk("curr", o_curr_line, pat(pairs / 64, {c, 1'b0, 6'(pairs % 64)}));
        chk("prev", o_prev_line, pat(pairs / 64, {p, 1'b0, 6'(pairs % 64)}));
        chk("last", 128'(o_last), 128'(pairs == 1023));
        if (pairs == stall_at && stall_cnt < 10) begin
          if (stall_cnt == 0) snap = o_curr_line;
          else chk("stall_hold", o_curr_line, snap);
          i_ready = 1'b0;
          stall_cnt++;
        end
        if (i_ready) begin
          pairs++;
          last_acc = cyc;
        end
      end
      if (o_done) begin
        chk("done_cycle", 128'(cyc), 128'(last_acc + 1));
        chk("done_pairs", 128'(pairs), 128'(1024));
        chk("done_busy", 128'(o_busy), 128'(0));
        fin = 1'b1;
      end
      if (pairs == chg_at) i_curr_frame_loc = 2'd0;
      if (pairs == restart_at && !restarted) begin
        i_start = 1'b1;
        restarted = 1'b1;
      end
      if (pairs == rst_at) begin
        i_resetn = 1'b0;
        @(negedge i_clk);
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_busy", 128'(o_busy), 128'(0));
        chk("rst_addr", 128'(o_bram_array_read_addr), 128'(0));
        chk("rst_done", 128'(o_done), 128'(0));
        chk("rst_curr", o_curr_line, 128'(0));
        i_resetn = 1'b1;
        return;
      end
    end
    if (!fin) begin
      bad++; total++;
      $display("FAIL pass_timeout act=%0d pairs exp=1024", pairs);
    end
    i_start = 1'b0;
    @(negedge i_clk);
    chk("done_pulse_width", 128'(o_done), 128'(0));
    chk("stall_cycles", 128'(stall_cnt), 128'(stall_at >= 0 ? 10 : 0));
  endtask

  typedef struct {
    logic [1:0] curr;
    logic [1:0] prev;
    logic       exp_err;
    logic       exp_busy;
  } start_vec_t;

  start_vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd2, 2'd2, 1'b1, 1'b0};
    vecs[1] = '{2'd0, 2'd0, 1'b1, 1'b0};
    vecs[2] = '{2'd3, 2'd3, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 2'd0, 1'b0, 1'b1};
    vecs[4] = '{2'd0, 2'd3, 1'b0, 1'b1};
    vecs[5] = '{2'd3, 2'd2, 1'b0, 1'b1};

    do_reset();
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_loc_err", 128'(o_loc_err), 128'(0));
    chk("rst_addr", 128'(o_bram_array_read_addr), 128'(0));
    chk("rst_curr", o_curr_line, 128'(0));
    chk("rst_prev", o_prev_line, 128'(0));
    chk("rst_last", 128'(o_last), 128'(0));
    chk("rst_idx", 128'({o_subimage_idx, o_line_idx}), 128'(0));

    for (int i = 0; i < 6; i++) begin
      logic [8:0] a0;
      do_reset();
      a0 = o_bram_array_read_addr;
      i_curr_frame_loc = vecs[i].curr;
      i_prev_frame_loc = vecs[i].prev;
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
      chk($sformatf("vec%0d_loc_err", i), 128'(o_loc_err), 128'(vecs[i].exp_err));
      chk($sformatf("vec%0d_busy", i), 128'(o_busy), 128'(vecs[i].exp_busy));
      if (vecs[i].exp_err)
        chk($sformatf("vec%0d_addr_idle", i), 128'(o_bram_array_read_addr), 128'(a0));
      else
        chk($sformatf("vec%0d_addr_curr", i), 128'(o_bram_array_read_addr),
            128'({vecs[i].curr, 7'd0}));
      @(negedge i_clk);
      chk($sformatf("vec%0d_loc_err_pulse", i), 128'(o_loc_err), 128'(0));
      chk($sformatf("vec%0d_busy_hold", i), 128'(o_busy), 128'(vecs[i].exp_busy));
      if (vecs[i].exp_err)
        chk($sformatf("vec%0d_addr_still", i), 128'(o_bram_array_read_addr), 128'(a0));
    end

    do_reset();
    run_pass(2'd1, 2'd0, -1, -1, -1, -1);
    run_pass(2'd2, 2'd3, 3 * 64 + 5, -1, -1, -1);
    run_pass(2'd1, 2'd3, -1, 100, -1, -1);
    run_pass(2'd3, 2'd1, -1, -1, 300, -1);
    run_pass(2'd0, 2'd1, -1, -1, -1, 500);
    run_pass(2'd1, 2'd0, -1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
